// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - shared types and constants for the SPI master arbiter
// Contents: arbiter state encoding, SPI byte width, default timing constants,
// and a small max helper used to size the shared cycle counter.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    WAIT,
    HOLD,
    DRAIN
  } arb_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// rtl/spi_master_arbiter_if.sv - requester and SPI-engine bus of the SPI master arbiter
// Signals:
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   rsp_valid/rsp_data                    : per-requester rx pulse, shared rx byte
//   m_start/m_tx_data/m_rx_data/m_done    : byte-level SPI master engine
//   cs_n, busy, grant_id, timeout_err, err_id : chip selects and status
// Modports: master = arbiter side, slave = requesters/engine/environment side.
interface spi_master_arbiter_if
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [SPI_BYTE_W-1:0]         rsp_data;
  logic                          m_start;
  logic [SPI_BYTE_W-1:0]         m_tx_data;
  logic [SPI_BYTE_W-1:0]         m_rx_data;
  logic                          m_done;
  logic [NUM_REQ-1:0]            cs_n;
  logic                          busy;
  logic [GW-1:0]                 grant_id;
  logic                          timeout_err;
  logic [GW-1:0]                 err_id;

  modport master (
    input  req_valid, req_data, req_last, m_rx_data, m_done,
    output req_ready, rsp_valid, rsp_data, m_start, m_tx_data,
           cs_n, busy, grant_id, timeout_err, err_id
  );

  modport slave (
    output req_valid, req_data, req_last, m_rx_data, m_done,
    input  req_ready, rsp_valid, rsp_data, m_start, m_tx_data,
           cs_n, busy, grant_id, timeout_err, err_id
  );

endinterface

// File: rtl/spi_master_arbiter_rr_picker.sv
// rtl/spi_master_arbiter_rr_picker.sv - combinational round-robin requester select
// Ports:
//   req   in  NUM_REQ  request vector
//   rr    in  GW       index of the last served requester
//   grant out GW       first set request searching from rr+1 upward with wrap
//   any   out 1        at least one request set
module spi_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr,
  output logic [GW-1:0]      grant,
  output logic               any
);

  logic [GW-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest
  // set bit after rr is the one left in grant.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(rr) + k) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one byte SPI master between requesters
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      master modport of spi_master_arbiter_if (requester handshakes,
//            SPI engine start/done, chip selects, status and watchdog error)
// Bursts hold the grant until req_last; cs_n brackets each burst with
// SETUP_CYC/HOLD_CYC margins; a stalled engine is aborted after TIMEOUT_CYC
// and the rest of that burst is drained without touching the engine.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   reset_n,
  spi_master_arbiter_if.master   bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max3(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);

  arb_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [NUM_REQ-1:0]    cs_q, cs_d;
  logic                  last_q, last_d;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d;
  logic                  start_q, start_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [SPI_BYTE_W-1:0] rsp_data_q, rsp_data_d;
  logic                  terr_q, terr_d;
  logic [GW-1:0]         err_id_q, err_id_d;
  logic [NUM_REQ-1:0]    ready;

  logic [GW-1:0]         pick_id;
  logic                  pick_any;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req   (bus.req_valid),
    .rr    (rr_q),
    .grant (pick_id),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      rr_q        <= GW'(NUM_REQ - 1);
      cs_q        <= '1;
      last_q      <= 1'b0;
      tx_q        <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      terr_q      <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cs_q        <= cs_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      terr_q      <= terr_d;
      err_id_q    <= err_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cs_d        = cs_q;
    last_d      = last_q;
    tx_d        = tx_q;
    start_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    terr_d      = 1'b0;
    err_id_d    = err_id_q;
    ready       = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d          = pick_id;
          cs_d             = '1;
          cs_d[pick_id]    = 1'b0;
          cnt_d            = '0;
          state_d          = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) state_d = LAUNCH;
        else                             cnt_d   = cnt_q + 1'b1;
      end

      LAUNCH: begin
        ready[grant_q] = bus.req_valid[grant_q];
        if (bus.req_valid[grant_q]) begin
          tx_d    = bus.req_data[{grant_q, 3'b000} +: SPI_BYTE_W];
          last_d  = bus.req_last[grant_q];
          start_d = 1'b1;
          // Counter is zero in the cycle m_start is high.
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A done arriving on the final watchdog cycle still completes the byte.
        if (bus.m_done) begin
          rsp_data_d           = bus.m_rx_data;
          rsp_valid_d[grant_q] = 1'b1;
          cnt_d                = '0;
          state_d              = last_q ? HOLD : LAUNCH;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          terr_d   = 1'b1;
          err_id_d = grant_q;
          cs_d     = '1;
          rr_d     = grant_q;
          state_d  = last_q ? IDLE : DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          cs_d    = '1;
          rr_d    = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        // Swallow the rest of the aborted burst so the requester can finish.
        ready[grant_q] = bus.req_valid[grant_q];
        if (bus.req_valid[grant_q] && bus.req_last[grant_q]) begin
          rr_d    = grant_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.m_start     = start_q;
  assign bus.m_tx_data   = tx_q;
  assign bus.cs_n        = cs_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;
  import spi_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(N)) bus_a ();
  spi_master_arbiter_if #(.NUM_REQ(N)) bus_t ();

  spi_master_arbiter #(
    .NUM_REQ(N), .SETUP_CYC(4), .HOLD_CYC(4), .TIMEOUT_CYC(4096)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  spi_master_arbiter #(
    .NUM_REQ(N), .SETUP_CYC(4), .HOLD_CYC(4), .TIMEOUT_CYC(64)
  ) dut_t (
    .clk(clk), .reset_n(reset_n), .bus(bus_t)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t       exp_start_q[$];
  exp_t       exp_rsp_q[$];
  logic [7:0] mrx_q[$];

  task automatic push_exp(input logic [1:0] id, input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    e.id = id; e.tx = tx; e.rx = rx;
    exp_start_q.push_back(e);
    exp_rsp_q.push_back(e);
    mrx_q.push_back(rx);
  endtask

  // DUT A: scoreboard monitor plus SPI engine model with programmable latency
  int         delay_a = 20;
  int         cnt_a = 0;
  logic [7:0] rx_cur_a = '0;
  int         starts_a = 0;
  int         low_run = 0, last_low_len = 0, low_runs = 0;
  exp_t       e_a;
  logic [N-1:0] vec_a;

  always @(negedge clk) begin
    if (!reset_n) begin
      cnt_a = 0;
      low_run = 0;
      bus_a.m_done = 1'b0;
      bus_a.m_rx_data = '0;
    end else begin
      if (bus_a.m_start) begin
        starts_a++;
        if (exp_start_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          e_a = exp_start_q.pop_front();
          check("start_grant", 32'(bus_a.grant_id), 32'(e_a.id));
          check("start_tx", 32'(bus_a.m_tx_data), 32'(e_a.tx));
        end
      end
      if (bus_a.rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e_a = exp_rsp_q.pop_front();
          vec_a = '0;
          vec_a[e_a.id] = 1'b1;
          check("rsp_vec", 32'(bus_a.rsp_valid), 32'(vec_a));
          check("rsp_data", 32'(bus_a.rsp_data), 32'(e_a.rx));
        end
      end
      if (bus_a.cs_n != '1) begin
        low_run++;
        check("cs_onehot", $countones(~bus_a.cs_n), 1);
      end else if (low_run > 0) begin
        last_low_len = low_run;
        low_runs++;
        low_run = 0;
      end
      bus_a.m_done = 1'b0;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          bus_a.m_done = 1'b1;
          bus_a.m_rx_data = rx_cur_a;
        end
      end
      if (bus_a.m_start) begin
        cnt_a = delay_a;
        rx_cur_a = (mrx_q.size() > 0) ? mrx_q.pop_front() : 8'h00;
      end
    end
  end

  // DUT T: watchdog instance; delay_t == 0 means the engine never answers
  int           cyc = 0;
  int           delay_t = 0, cnt_t = 0;
  logic [7:0]   rx_t = '0;
  int           starts_t = 0, rsp_t_cnt = 0, terr_cnt = 0;
  int           start_cyc_t = 0, terr_cyc_t = 0;
  logic [N-1:0] rsp_t_vec = '0, cs_at_terr = '0;
  logic [7:0]   rsp_t_data = '0;
  logic [1:0]   err_at_terr = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      cnt_t = 0;
      bus_t.m_done = 1'b0;
      bus_t.m_rx_data = '0;
    end else begin
      if (bus_t.m_start) begin
        starts_t++;
        start_cyc_t = cyc;
      end
      if (bus_t.rsp_valid != '0) begin
        rsp_t_cnt++;
        rsp_t_vec = bus_t.rsp_valid;
        rsp_t_data = bus_t.rsp_data;
      end
      if (bus_t.timeout_err) begin
        terr_cnt++;
        terr_cyc_t = cyc;
        cs_at_terr = bus_t.cs_n;
        err_at_terr = bus_t.err_id;
      end
      bus_t.m_done = 1'b0;
      if (cnt_t > 0) begin
        cnt_t--;
        if (cnt_t == 0) begin
          bus_t.m_done = 1'b1;
          bus_t.m_rx_data = rx_t;
        end
      end
      if (bus_t.m_start && delay_t > 0) cnt_t = delay_t;
    end
  end

  task automatic drive_req(input bit b, input logic [1:0] id, input logic [7:0] d,
                           input bit l, input bit v);
    if (b) begin
      bus_t.req_valid[id] = v;
      bus_t.req_data[{id, 3'b000} +: 8] = d;
      bus_t.req_last[id] = l;
    end else begin
      bus_a.req_valid[id] = v;
      bus_a.req_data[{id, 3'b000} +: 8] = d;
      bus_a.req_last[id] = l;
    end
  endtask

  function automatic bit ready_of(input bit b, input logic [1:0] id);
    return b ? bus_t.req_ready[id] : bus_a.req_ready[id];
  endfunction

  function automatic bit busy_of(input bit b);
    return b ? bus_t.busy : bus_a.busy;
  endfunction

  task automatic send_byte(input bit b, input logic [1:0] id, input logic [7:0] d, input bit l);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    drive_req(b, id, d, l, 1'b1);
    for (int i = 0; i < 3000 && !ok; i++) begin
      #1;
      if (ready_of(b, id)) ok = 1'b1;
      else @(negedge clk);
    end
    check("handshake", 32'(ok), 1);
    @(negedge clk);
    drive_req(b, id, d, l, 1'b0);
  endtask

  task automatic wait_idle(input bit b);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      if (!busy_of(b)) idle = 1'b1;
    end
    check("reach_idle", 32'(idle), 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  int s0, r0;

  initial begin
    bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_last = '0;
    bus_t.req_valid = '0; bus_t.req_data = '0; bus_t.req_last = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(bus_a.cs_n), 32'hF);
    check("rst_m_start", 32'(bus_a.m_start), 0);
    check("rst_m_tx_data", 32'(bus_a.m_tx_data), 0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus_a.rsp_data), 0);
    check("rst_timeout_err", 32'(bus_a.timeout_err), 0);
    check("rst_err_id", 32'(bus_a.err_id), 0);
    check("rst_grant_id", 32'(bus_a.grant_id), 0);
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_req_ready", 32'(bus_a.req_ready), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Contention from reset: expected grant order 0, 1, 3 then 0, 1
    delay_a = 20;
    push_exp(2'd0, 8'h10, 8'hC0);
    push_exp(2'd1, 8'h11, 8'hC1);
    push_exp(2'd3, 8'h13, 8'hC3);
    fork
      send_byte(1'b0, 2'd0, 8'h10, 1'b1);
      send_byte(1'b0, 2'd1, 8'h11, 1'b1);
      send_byte(1'b0, 2'd3, 8'h13, 1'b1);
    join
    wait_idle(1'b0);
    push_exp(2'd0, 8'h20, 8'hD0);
    push_exp(2'd1, 8'h21, 8'hD1);
    fork
      send_byte(1'b0, 2'd0, 8'h20, 1'b1);
      send_byte(1'b0, 2'd1, 8'h21, 1'b1);
    join
    wait_idle(1'b0);
    check("contention_sb_empty", 32'(exp_rsp_q.size()), 0);

    // Single byte, 160-cycle engine: cs_n low 1+4+1+160+4 cycles
    delay_a = 160;
    s0 = starts_a;
    push_exp(2'd0, 8'h3C, 8'hA5);
    send_byte(1'b0, 2'd0, 8'h3C, 1'b1);
    wait_idle(1'b0);
    check("single_cs_len", 32'(last_low_len), 170);
    check("single_starts", 32'(starts_a - s0), 1);
    check("single_sb_empty", 32'(exp_rsp_q.size()), 0);

    // Three-byte burst on requester 2: one unbroken cs_n window
    delay_a = 20;
    s0 = starts_a;
    r0 = low_runs;
    push_exp(2'd2, 8'h01, 8'h11);
    push_exp(2'd2, 8'h02, 8'h22);
    push_exp(2'd2, 8'h03, 8'h33);
    send_byte(1'b0, 2'd2, 8'h01, 1'b0);
    send_byte(1'b0, 2'd2, 8'h02, 1'b0);
    send_byte(1'b0, 2'd2, 8'h03, 1'b1);
    wait_idle(1'b0);
    check("burst_cs_windows", 32'(low_runs - r0), 1);
    check("burst_cs_len", 32'(last_low_len), 74);
    check("burst_starts", 32'(starts_a - s0), 3);
    check("burst_busy", 32'(bus_a.busy), 0);
    check("burst_sb_empty", 32'(exp_rsp_q.size()), 0);

    // Reset during the m_start cycle of byte 2 of 3
    delay_a = 160;
    push_exp(2'd2, 8'h31, 8'hE1);
    push_exp(2'd2, 8'h32, 8'hE2);
    send_byte(1'b0, 2'd2, 8'h31, 1'b0);
    send_byte(1'b0, 2'd2, 8'h32, 1'b0);
    check("midrst_pre_start", 32'(bus_a.m_start), 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(bus_a.cs_n), 32'hF);
    check("midrst_m_start", 32'(bus_a.m_start), 0);
    check("midrst_busy", 32'(bus_a.busy), 0);
    repeat (2) @(negedge clk);
    exp_start_q.delete();
    exp_rsp_q.delete();
    mrx_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    delay_a = 20;
    push_exp(2'd0, 8'h40, 8'hF0);
    push_exp(2'd3, 8'h43, 8'hF3);
    fork
      send_byte(1'b0, 2'd0, 8'h40, 1'b1);
      send_byte(1'b0, 2'd3, 8'h43, 1'b1);
    join
    wait_idle(1'b0);
    check("postrst_sb_empty", 32'(exp_rsp_q.size()), 0);

    // Watchdog: engine never answers requester 1's first byte
    delay_t = 0;
    send_byte(1'b1, 2'd1, 8'h55, 1'b0);
    send_byte(1'b1, 2'd1, 8'h66, 1'b1);
    wait_idle(1'b1);
    check("to_err_count", 32'(terr_cnt), 1);
    check("to_latency", 32'(terr_cyc_t - start_cyc_t), 64);
    check("to_err_id", 32'(err_at_terr), 1);
    check("to_cs_n", 32'(cs_at_terr), 32'hF);
    check("to_drain_starts", 32'(starts_t), 1);
    check("to_no_rsp", 32'(rsp_t_cnt), 0);
    check("to_err_id_hold", 32'(bus_t.err_id), 1);

    // Next requester served normally after the drain
    delay_t = 10;
    rx_t = 8'h77;
    send_byte(1'b1, 2'd2, 8'h70, 1'b1);
    wait_idle(1'b1);
    check("after_to_rsp_count", 32'(rsp_t_cnt), 1);
    check("after_to_rsp_vec", 32'(rsp_t_vec), 32'h4);
    check("after_to_rsp_data", 32'(rsp_t_data), 32'h77);
    check("after_to_starts", 32'(starts_t), 2);

    // m_done on the final watchdog cycle wins
    delay_t = 63;
    rx_t = 8'h88;
    send_byte(1'b1, 2'd3, 8'h71, 1'b1);
    wait_idle(1'b1);
    check("tie_rsp_count", 32'(rsp_t_cnt), 2);
    check("tie_rsp_vec", 32'(rsp_t_vec), 32'h8);
    check("tie_rsp_data", 32'(rsp_t_data), 32'h88);
    check("tie_no_timeout", 32'(terr_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
